// File: rtl/mbc_sync_mapper_if.sv
// Cartridge-edge bus between the GB connector (master) and the mbc_sync_mapper bank controller (slave).
`timescale 1ns/1ps
interface mbc_sync_mapper_if #(
    parameter int ROM_BANK_W = 9,
    parameter int RAM_BANK_W = 4
);
    logic [15:12]          GB_A;
    logic [7:0]            GB_D;
    logic                  GB_CS;
    logic                  GB_WR;
    logic                  GB_RD;
    logic [ROM_BANK_W-1:0] ROM_A;
    logic [RAM_BANK_W-1:0] RAM_A;
    logic                  ROM_CS;
    logic                  RAM_CS;
    logic                  DDIR;
    logic                  DEBUG;

    modport master (
        output GB_A, GB_D, GB_CS, GB_WR, GB_RD,
        input  ROM_A, RAM_A, ROM_CS, RAM_CS, DDIR, DEBUG
    );

    modport slave (
        input  GB_A, GB_D, GB_CS, GB_WR, GB_RD,
        output ROM_A, RAM_A, ROM_CS, RAM_CS, DDIR, DEBUG
    );
endinterface

// File: rtl/mbc_sync_mapper.sv
// Clocked Game Boy MBC1/MBC5 bank controller with a GB_WR synchroniser and combinational chip selects.
// Optional macro NCGB_WR_GLITCH_FILTER_EN: require two consecutive low samples of WR before arming.
`timescale 1ns/1ps
module mbc_sync_mapper #(
    parameter int MODE       = 5,
    parameter int ROM_BANK_W = 9,
    parameter int RAM_BANK_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    mbc_sync_mapper_if.slave bus
);

    logic         s1, s2, s3;
    logic [1:0]   sync_valid;
    logic         idle_seen;
    logic         arm;
    logic         debug_q;
    logic [15:12] addr_q;
    logic [7:0]   data_q;
    logic         qualify;
    logic         commit;

    logic [ROM_BANK_W-1:0] bank0;
    logic [ROM_BANK_W-1:0] rom_bank_eff;
    logic [RAM_BANK_W-1:0] ram_bank_eff;
    logic                  ram_en;
    logic                  rom_cs_n;
    logic                  ram_cs_n;

    // A WR low only counts once a genuine high has been sampled after reset,
    // so a strobe that fell before or during reset never commits.
`ifdef NCGB_WR_GLITCH_FILTER_EN
    assign qualify = ~s2 & ~s3 & idle_seen;
`else
    assign qualify = ~s2 & idle_seen;
`endif

    assign commit = s2 & ~s3 & arm;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1         <= 1'b1;
            s2         <= 1'b1;
            s3         <= 1'b1;
            sync_valid <= 2'b00;
            idle_seen  <= 1'b0;
            arm        <= 1'b0;
            debug_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            s1         <= bus.GB_WR;
            s2         <= s1;
            s3         <= s2;
            sync_valid <= {sync_valid[0], 1'b1};
            if (sync_valid[1] && s2) begin
                idle_seen <= 1'b1;
            end
            if (!s2) begin
                addr_q <= bus.GB_A;
                data_q <= bus.GB_D;
            end
            if (commit) begin
                arm <= 1'b0;
            end else if (qualify) begin
                arm <= 1'b1;
            end
            debug_q <= commit;
        end
    end

    if (MODE == 5) begin : g_mbc5
        logic [8:0] rom_bank;
        logic [3:0] ram_bank;
        logic       ram_en_r;

        always_ff @(posedge CLK) begin
            if (RST) begin
                rom_bank <= 9'd1;
                ram_bank <= 4'd0;
                ram_en_r <= 1'b0;
            end else if (commit) begin
                case (addr_q)
                    4'h0, 4'h1: ram_en_r      <= (data_q[3:0] == 4'hA);
                    4'h2:       rom_bank[7:0] <= data_q;
                    4'h3:       rom_bank[8]   <= data_q[0];
                    4'h4, 4'h5: ram_bank      <= data_q[3:0];
                    default:    ;
                endcase
            end
        end

        assign bank0        = '0;
        assign rom_bank_eff = ROM_BANK_W'(rom_bank);
        assign ram_bank_eff = RAM_BANK_W'(ram_bank);
        assign ram_en       = ram_en_r;
    end else if (MODE == 1) begin : g_mbc1
        if (ROM_BANK_W < 7) begin : g_bad_rom_w
            $error("mbc_sync_mapper: MBC1 needs ROM_BANK_W >= 7");
        end

        logic [4:0] rom_lo;
        logic [1:0] hi2;
        logic       bmode;
        logic       ram_en_r;

        // A zero low field maps to bank 1, so bank 0 is only reachable through the 0x0000 region.
        always_ff @(posedge CLK) begin
            if (RST) begin
                rom_lo   <= 5'd1;
                hi2      <= 2'd0;
                bmode    <= 1'b0;
                ram_en_r <= 1'b0;
            end else if (commit) begin
                case (addr_q)
                    4'h0, 4'h1: ram_en_r <= (data_q[3:0] == 4'hA);
                    4'h2, 4'h3: rom_lo   <= (data_q[4:0] == 5'd0) ? 5'd1 : data_q[4:0];
                    4'h4, 4'h5: hi2      <= data_q[1:0];
                    4'h6, 4'h7: bmode    <= data_q[0];
                    default:    ;
                endcase
            end
        end

        assign bank0        = ROM_BANK_W'({(bmode ? hi2 : 2'b00), 5'b00000});
        assign rom_bank_eff = ROM_BANK_W'({hi2, rom_lo});
        assign ram_bank_eff = RAM_BANK_W'(bmode ? hi2 : 2'b00);
        assign ram_en       = ram_en_r;
    end else begin : g_bad_mode
        $error("mbc_sync_mapper: MODE must be 1 (MBC1) or 5 (MBC5)");
        assign bank0        = '0;
        assign rom_bank_eff = '0;
        assign ram_bank_eff = '0;
        assign ram_en       = 1'b0;
    end

    assign rom_cs_n = ~(~bus.GB_A[15] & ~bus.GB_RD);
    assign ram_cs_n = ~(~bus.GB_CS & (bus.GB_A[15:13] == 3'b101) & ram_en);

    assign bus.ROM_A  = (bus.GB_A[15:14] == 2'b00) ? bank0 : rom_bank_eff;
    assign bus.RAM_A  = ram_bank_eff;
    assign bus.ROM_CS = rom_cs_n;
    assign bus.RAM_CS = ram_cs_n;
    assign bus.DDIR   = ~bus.GB_RD & (~rom_cs_n | ~ram_cs_n);
    assign bus.DEBUG  = debug_q;

endmodule
